// File: rtl/apb_master_bridge_if.sv
// Bundles the bridge's command/response port with the APB3 master bus so the
// bridge, the bench and the slave agents all share one set of wires.
interface apb_master_bridge_if;
    // Handshakes: a transfer happens on the rising PCLK edge where valid and
    // ready are both 1; valid and its payload stay stable until then.
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [15:0] PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_sel,
        input  rsp_ready, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_sel,
        output rsp_ready, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB3 master bridge with a per-access
// wait-state timeout and a bad-slave-index short cut.
module apb_master_bridge #(
    parameter int NUM_SEL = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    apb_master_bridge_if.master        bus,
    output logic [1:0]                 dbg_state
);

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [15:0]     SEL_MASK = 16'((32'd1 << NUM_SEL) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             sel_ok;
    logic             xfer_done;
    logic [3:0]       sel_q;
    logic [3:0]       sel_src;
    logic [15:0]      psel_onehot;
    logic [CNT_W-1:0] wait_cnt;

    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        xfer_done = 1'b0;
        sel_ok    = ({1'b0, bus.req_sel} < 5'(NUM_SEL));
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    accept  = 1'b1;
                    state_d = sel_ok ? S_SETUP : S_RESP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                // A ready slave wins over the timeout on the last allowed cycle.
                if (bus.PREADY) begin
                    xfer_done = 1'b1;
                    state_d   = S_RESP;
                end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // The select comes straight from the request on the accepting edge.
    assign sel_src     = accept ? bus.req_sel : sel_q;
    assign psel_onehot = SEL_MASK & (16'd1 << sel_src);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sel_q         <= '0;
            bus.req_ready <= 1'b0;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.PWRITE    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.req_ready <= (state_d == S_IDLE);
            bus.PSEL      <= ((state_d == S_SETUP) || (state_d == S_ACCESS)) ? psel_onehot : '0;
            bus.PENABLE   <= (state_d == S_ACCESS);
            bus.rsp_valid <= (state_d == S_RESP);

            if (accept) sel_q <= bus.req_sel;

            // Bad-index requests never reach the bus, so the held address stays put.
            if (accept && sel_ok) begin
                bus.PADDR  <= bus.req_addr;
                bus.PWDATA <= bus.req_wdata;
                bus.PWRITE <= bus.req_write;
            end

            if ((state_q != S_RESP) && (state_d == S_RESP)) begin
                bus.rsp_err   <= !xfer_done;
                bus.rsp_rdata <= (xfer_done && !bus.PWRITE) ? bus.PRDATA : '0;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state_q != S_ACCESS) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, reset-mid-access sequence
// and randomized transactions against a transaction-level reference model.
module tb_apb_master_bridge;

    localparam int NUM_SEL = 8;
    localparam int TIMEOUT = 4;
    localparam logic [15:0] SEL_MASK = 16'((32'd1 << NUM_SEL) - 32'd1);

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [1:0] dbg_state;

    apb_master_bridge_if bus();

    apb_master_bridge #(.NUM_SEL(NUM_SEL), .TIMEOUT(TIMEOUT)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] prdata;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;   // negedges after the accepting edge until rsp_valid is seen
        int          exp_pen;   // cycles with PENABLE high
        logic [15:0] exp_psel;
    } vec_t;

    int          n_tests    = 0;
    int          n_fail     = 0;
    int          proto_viol = 0;
    int          hold_err   = 0;
    logic [32:0] exp_q[$];
    logic [15:0] prev_psel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus rules that must hold on every cycle out of reset.
    always @(negedge PCLK) begin
        if (PRESET) begin
            prev_psel <= '0;
        end else begin
            if ($isunknown(bus.PSEL) || (bus.PENABLE && bus.PSEL == 16'd0) ||
                ($countones(bus.PSEL) > 1) || ((bus.PSEL & ~SEL_MASK) != 16'd0) ||
                (bus.PSEL != 16'd0 && prev_psel == 16'd0 && bus.PENABLE))
                proto_viol <= proto_viol + 1;
            prev_psel <= bus.PSEL;
        end
    end

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int ws, input logic [31:0] pr,
                                input int h, input logic e, input logic [31:0] rd,
                                input int lat, input int pen, input logic [15:0] ps);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.sel = s; v.waits = ws; v.prdata = pr;
        v.hold = h; v.exp_err = e; v.exp_rdata = rd; v.exp_lat = lat; v.exp_pen = pen;
        v.exp_psel = ps;
        return v;
    endfunction

    // Transaction-level reference: outcome, latency and bus footprint of one request.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        if (int'(v.sel) >= NUM_SEL) begin
            r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_lat = 1; r.exp_pen = 0; r.exp_psel = '0;
        end else begin
            r.exp_psel = 16'd1 << v.sel;
            if (TIMEOUT != 0 && v.waits >= TIMEOUT) begin
                r.exp_err = 1'b1; r.exp_rdata = '0;
                r.exp_lat = 2 + TIMEOUT; r.exp_pen = TIMEOUT;
            end else begin
                r.exp_err = 1'b0; r.exp_rdata = v.write ? 32'd0 : v.prdata;
                r.exp_lat = 3 + v.waits; r.exp_pen = v.waits + 1;
            end
        end
        return r;
    endfunction

    // ---------------- driver: one full transaction, called on a negedge in IDLE ----------------
    task automatic run_txn(input vec_t v);
        int          k;
        int          pen_n;
        int          psel_n;
        int          exp_psel_n;
        logic        got;
        logic [15:0] psel_seen;
        logic [31:0] addr_seen;
        logic [31:0] wdata_seen;
        logic        wr_seen;
        logic [32:0] exp;

        exp_q.push_back({v.exp_err, v.exp_rdata});
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_write = v.write;
        bus.req_wdata = v.wdata;
        bus.req_sel   = v.sel;
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        bus.req_write = ~v.write;
        bus.req_wdata = $urandom();
        bus.req_sel   = 4'($urandom_range(0, 15));

        k = 1; pen_n = 0; psel_n = 0; got = 1'b0;
        psel_seen = '0; addr_seen = '0; wdata_seen = '0; wr_seen = 1'b0;
        while (!got && k <= 40) begin
            if (bus.PSEL != 16'd0) begin
                psel_n++;
                if (!bus.PENABLE) begin
                    psel_seen = bus.PSEL; addr_seen = bus.PADDR;
                    wdata_seen = bus.PWDATA; wr_seen = bus.PWRITE;
                end
            end
            if (bus.PENABLE) begin
                if (bus.PSEL !== psel_seen || bus.PADDR !== v.addr) hold_err++;
                bus.PREADY = (pen_n >= v.waits);
                bus.PRDATA = bus.PREADY ? v.prdata : $urandom();
                pen_n++;
            end else begin
                bus.PREADY = 1'($urandom_range(0, 1));
                bus.PRDATA = $urandom();
            end
            if (bus.rsp_valid) got = 1'b1;
            else begin
                @(negedge PCLK);
                k++;
            end
        end

        exp = exp_q.pop_front();
        check("rsp_seen", 32'(got), 32'd1);
        if (!got) return;
        check("rsp_err", 32'(bus.rsp_err), 32'(exp[32]));
        check("rsp_rdata", bus.rsp_rdata, exp[31:0]);
        check("latency", 32'(k), 32'(v.exp_lat));
        check("penable_cycles", 32'(pen_n), 32'(v.exp_pen));
        exp_psel_n = (v.exp_psel != 16'd0) ? v.exp_pen + 1 : 0;
        check("psel_cycles", 32'(psel_n), 32'(exp_psel_n));
        check("psel_value", 32'(psel_seen), 32'(v.exp_psel));
        if (v.exp_psel != 16'd0) begin
            check("paddr", addr_seen, v.addr);
            check("pwdata", wdata_seen, v.wdata);
            check("pwrite", 32'(wr_seen), 32'(v.write));
        end

        if (v.hold > 0) begin
            bus.rsp_ready = 1'b0;
            repeat (v.hold) begin
                @(negedge PCLK);
                check("bp_flags", 32'({bus.rsp_valid, bus.req_ready, bus.PENABLE, bus.rsp_err}),
                      32'({1'b1, 1'b0, 1'b0, exp[32]}));
                check("bp_rdata_psel", bus.rsp_rdata | 32'(bus.PSEL), exp[31:0]);
            end
            bus.rsp_ready = 1'b1;
        end
        @(negedge PCLK);
        check("handshake_idle", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
        if (v.exp_psel != 16'd0) check("paddr_hold", bus.PADDR, v.addr);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[8];
    vec_t rv;

    initial begin
        tbl[0] = mk(1'b1, 32'h10, 32'hDEADBEEF, 4'd2, 0, 32'h55555555, 0, 1'b0, 32'h0,        3, 1, 16'h0004);
        tbl[1] = mk(1'b0, 32'h20, 32'h0,        4'd0, 2, 32'h12345678, 0, 1'b0, 32'h12345678, 5, 3, 16'h0001);
        tbl[2] = mk(1'b0, 32'h30, 32'h0,        4'd5, 9, 32'hCAFEF00D, 0, 1'b1, 32'h0,        6, 4, 16'h0020);
        tbl[3] = mk(1'b1, 32'h40, 32'h0F0F0F0F, 4'd1, 0, 32'h0,        0, 1'b0, 32'h0,        3, 1, 16'h0002);
        tbl[4] = mk(1'b0, 32'h44, 32'h0,        4'd9, 0, 32'h11111111, 0, 1'b1, 32'h0,        1, 0, 16'h0000);
        tbl[5] = mk(1'b0, 32'h50, 32'h0,        4'd7, 0, 32'hAABBCCDD, 5, 1'b0, 32'hAABBCCDD, 3, 1, 16'h0080);
        tbl[6] = mk(1'b0, 32'h60, 32'h0,        4'd3, 3, 32'h0BADF00D, 0, 1'b0, 32'h0BADF00D, 6, 4, 16'h0008);
        tbl[7] = mk(1'b1, 32'h70, 32'h1234,     4'd15, 0, 32'h0,       2, 1'b1, 32'h0,        1, 0, 16'h0000);

        PRESET = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
        bus.req_sel = '0; bus.rsp_ready = 1'b1; bus.PRDATA = '0; bus.PREADY = 1'b0;
        #1;
        check("rst_psel_pen", 32'({bus.PSEL, bus.PENABLE}), 32'd0);
        check("rst_paddr_pwdata", bus.PADDR | bus.PWDATA, 32'd0);
        check("rst_flags", 32'({bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.req_ready}), 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("req_ready_before_edge", 32'(bus.req_ready), 32'd0);
        @(negedge PCLK);
        check("req_ready_after_edge", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Reset while the slave is stalling the access phase.
        bus.req_valid = 1'b1; bus.req_addr = 32'h80; bus.req_write = 1'b0;
        bus.req_wdata = 32'h0; bus.req_sel = 4'd4; bus.PREADY = 1'b0;
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        @(negedge PCLK);
        check("mid_access_penable", 32'({bus.PSEL, bus.PENABLE}), 32'({16'h0010, 1'b1}));
        @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1;
        check("mid_rst_bus", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.req_ready}), 32'd0);
        check("mid_rst_paddr", bus.PADDR, 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("mid_rel_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge PCLK);
        check("mid_rel_req_ready_edge", 32'(bus.req_ready), 32'd1);
        repeat (3) begin
            @(negedge PCLK);
            check("no_rsp_after_reset", 32'({bus.rsp_valid, bus.PSEL}), 32'd0);
        end
        run_txn(tbl[0]);

        for (int i = 0; i < 40; i++) begin
            rv.write  = 1'($urandom_range(0, 1));
            rv.addr   = $urandom();
            rv.wdata  = $urandom();
            rv.sel    = 4'($urandom_range(0, 15));
            rv.waits  = $urandom_range(0, 6);
            rv.prdata = $urandom();
            rv.hold   = $urandom_range(0, 3);
            run_txn(predict(rv));
        end

        check("protocol", 32'(proto_viol), 32'd0);
        check("psel_held", 32'(hold_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
